// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Used by arb_pick and imem_dmem_arbiter.
package arb_pkg;

  // Width of the latency and starvation counters; both count at most 15.
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_t;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [LAT_CNT_W-1:0] sat_inc(
    input logic [LAT_CNT_W-1:0] val,
    input logic [LAT_CNT_W-1:0] lim
  );
    return (val >= lim) ? lim : val + LAT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_pick.sv
// Combinational winner selection for the memory arbiter.
// Build option: IMEM_DMEM_ARB_RR_EN selects strict round-robin; when it is
// undefined, LS has priority and IF is forced through after STARVE_MAX losses.
module arb_pick
  import arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                 if_req,
  input  logic                 ls_req,
  input  logic [LAT_CNT_W-1:0] starve_cnt,
  input  arb_owner_t           last_win,
  output logic                 any_req,
  output arb_owner_t           winner,
  output logic [LAT_CNT_W-1:0] starve_nxt
);

`ifdef IMEM_DMEM_ARB_RR_EN
  // The starvation count has no meaning under round-robin.
  logic unused_starve;
  assign unused_starve = ^starve_cnt;

  // On a tie, the requester that did not win last time goes next.
  always_comb begin
    any_req    = if_req | ls_req;
    winner     = OWN_LS;
    starve_nxt = '0;
    if (if_req && ls_req) begin
      winner = (last_win == OWN_LS) ? OWN_IF : OWN_LS;
    end else if (if_req) begin
      winner = OWN_IF;
    end
  end
`else
  // Winner history only matters under round-robin.
  logic unused_last_win;
  assign unused_last_win = (last_win == OWN_LS);

  // LS wins ties unless IF has already lost STARVE_MAX times in a row.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave a value unassigned and infer a latch.
    any_req    = if_req | ls_req;
    winner     = OWN_LS;
    starve_nxt = '0;
    if (if_req && (!ls_req || starve_cnt == LAT_CNT_W'(STARVE_MAX))) begin
      winner = OWN_IF;
    end
    if (if_req && winner == OWN_LS) begin
      starve_nxt = sat_inc(starve_cnt, LAT_CNT_W'(STARVE_MAX));
    end
  end
`endif

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and
// load/store (LS). Each access runs issue -> fixed-latency wait -> response;
// arbitration happens in idle and in the response cycle, so back-to-back
// transactions take MEM_LAT+2 cycles. All outputs are registered.
// Build option: IMEM_DMEM_ARB_RR_EN (round-robin arbitration, see arb_pick).
module imem_dmem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                IF_REQ,
  input  logic [ADDR_W-1:0]   IF_ADDR,
  output logic                IF_GNT,
  output logic                IF_RVALID,
  output logic [DATA_W-1:0]   IF_RDATA,
  input  logic                LS_REQ,
  input  logic                LS_WE,
  input  logic [ADDR_W-1:0]   LS_ADDR,
  input  logic [DATA_W-1:0]   LS_WDATA,
  input  logic [DATA_W/8-1:0] LS_BE,
  output logic                LS_GNT,
  output logic                LS_RVALID,
  output logic [DATA_W-1:0]   LS_RDATA,
  output logic                MEM_EN,
  output logic                MEM_WE,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic [DATA_W-1:0]   MEM_WDATA,
  output logic [DATA_W/8-1:0] MEM_BE,
  input  logic [DATA_W-1:0]   MEM_RDATA,
  output logic                BUSY
);

  localparam int BE_W = DATA_W / 8;

  // Control state
  arb_state_t           state_q, state_d;
  arb_owner_t           owner_q, owner_d;
  arb_owner_t           last_win_q, last_win_d;
  logic                 txn_we_q, txn_we_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [LAT_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Output registers
  logic              if_gnt_q, if_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              ls_gnt_q, ls_gnt_d;
  logic              ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              busy_q, busy_d;

  // Arbitration decision for the current cycle
  logic                 pick_any;
  arb_owner_t           pick_winner;
  logic [LAT_CNT_W-1:0] pick_starve_nxt;

  arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .if_req     (IF_REQ),
    .ls_req     (LS_REQ),
    .starve_cnt (starve_cnt_q),
    .last_win   (last_win_q),
    .any_req    (pick_any),
    .winner     (pick_winner),
    .starve_nxt (pick_starve_nxt)
  );

  // Next-state and next-output logic for the issue/wait/response sequence.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_win_d   = last_win_q;
    txn_we_d     = txn_we_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    // Strobes are single-cycle pulses: low unless a state raises them.
    if_gnt_d     = 1'b0;
    ls_gnt_d     = 1'b0;
    if_rvalid_d  = 1'b0;
    ls_rvalid_d  = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;

    case (state_q)
      S_IDLE, S_RESP: begin
        starve_cnt_d = pick_starve_nxt;
        if (pick_any) begin
          state_d    = S_ISSUE;
          owner_d    = pick_winner;
          last_win_d = pick_winner;
          mem_en_d   = 1'b1;
          if (pick_winner == OWN_IF) begin
            if_gnt_d    = 1'b1;
            mem_addr_d  = IF_ADDR;
            mem_wdata_d = '0;
            mem_be_d    = '1;
            txn_we_d    = 1'b0;
          end else begin
            ls_gnt_d    = 1'b1;
            mem_addr_d  = LS_ADDR;
            mem_wdata_d = LS_WDATA;
            mem_be_d    = LS_WE ? LS_BE : '1;
            txn_we_d    = LS_WE;
          end
          mem_we_d = txn_we_d;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        lat_cnt_d = LAT_CNT_W'(MEM_LAT);
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
        // Read data is valid in the last wait cycle; stores return zero.
        if (lat_cnt_q == LAT_CNT_W'(1)) begin
          state_d = S_RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d  = MEM_RDATA;
            if_rvalid_d = 1'b1;
          end else begin
            ls_rdata_d  = txn_we_q ? '0 : MEM_RDATA;
            ls_rvalid_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge CLK) begin
    // NOTE: registers use non-blocking assignment so every flop samples the
    // values from before this edge, independent of statement order.
    if (RSTN) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      last_win_q   <= OWN_LS;
      txn_we_q     <= 1'b0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      if_gnt_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      ls_gnt_q     <= 1'b0;
      ls_rvalid_q  <= 1'b0;
      ls_rdata_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_win_q   <= last_win_d;
      txn_we_q     <= txn_we_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      if_gnt_q     <= if_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      ls_gnt_q     <= ls_gnt_d;
      ls_rvalid_q  <= ls_rvalid_d;
      ls_rdata_q   <= ls_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      busy_q       <= busy_d;
    end
  end

  assign IF_GNT    = if_gnt_q;
  assign IF_RVALID = if_rvalid_q;
  assign IF_RDATA  = if_rdata_q;
  assign LS_GNT    = ls_gnt_q;
  assign LS_RVALID = ls_rvalid_q;
  assign LS_RDATA  = ls_rdata_q;
  assign MEM_EN    = mem_en_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign MEM_BE    = mem_be_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_imem_dmem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
  localparam int NCYC       = 1500;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b1;
  logic              IF_REQ = 1'b0;
  logic [ADDR_W-1:0] IF_ADDR = '0;
  logic              LS_REQ = 1'b0;
  logic              LS_WE = 1'b0;
  logic [ADDR_W-1:0] LS_ADDR = '0;
  logic [DATA_W-1:0] LS_WDATA = '0;
  logic [BE_W-1:0]   LS_BE = '0;
  logic              IF_GNT, IF_RVALID, LS_GNT, LS_RVALID;
  logic              MEM_EN, MEM_WE, BUSY;
  logic [DATA_W-1:0] IF_RDATA, LS_RDATA, MEM_WDATA, MEM_RDATA;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [BE_W-1:0]   MEM_BE;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  imem_dmem_arbiter #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .MEM_LAT (MEM_LAT), .STARVE_MAX (STARVE_MAX)
  ) dut (
    .CLK (CLK), .RSTN (RSTN),
    .IF_REQ (IF_REQ), .IF_ADDR (IF_ADDR), .IF_GNT (IF_GNT),
    .IF_RVALID (IF_RVALID), .IF_RDATA (IF_RDATA),
    .LS_REQ (LS_REQ), .LS_WE (LS_WE), .LS_ADDR (LS_ADDR), .LS_WDATA (LS_WDATA),
    .LS_BE (LS_BE), .LS_GNT (LS_GNT), .LS_RVALID (LS_RVALID), .LS_RDATA (LS_RDATA),
    .MEM_EN (MEM_EN), .MEM_WE (MEM_WE), .MEM_ADDR (MEM_ADDR), .MEM_WDATA (MEM_WDATA),
    .MEM_BE (MEM_BE), .MEM_RDATA (MEM_RDATA), .BUSY (BUSY)
  );

  // {IF_GNT, IF_RVALID, LS_GNT, LS_RVALID, MEM_EN, MEM_WE, BUSY}
  wire [6:0] pulses = {IF_GNT, IF_RVALID, LS_GNT, LS_RVALID, MEM_EN, MEM_WE, BUSY};

  // ---------------- memory environment ----------------
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] rd_pipe [MEM_LAT];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
  endfunction

  function automatic logic [31:0] env_get(input logic [31:0] a);
    if (env_mem.exists(a >> 2)) return env_mem[a >> 2];
    return init_word(a & 32'hFFFF_FFFC);
  endfunction

  assign MEM_RDATA = rd_pipe[MEM_LAT-1];

  // Fixed-latency memory: read data appears MEM_LAT cycles after MEM_EN,
  // random garbage in every other cycle.
  always @(posedge CLK) begin : env_mem_p
    logic [31:0] w;
    for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= $urandom;
    if (MEM_EN) begin
      if (MEM_WE) begin
        w = env_get(MEM_ADDR);
        for (int b = 0; b < BE_W; b++) if (MEM_BE[b]) w[8*b +: 8] = MEM_WDATA[8*b +: 8];
        env_mem[MEM_ADDR >> 2] = w;
      end else begin
        rd_pipe[0] <= env_get(MEM_ADDR);
      end
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTN = 1'b1; IF_REQ = 1'b0; LS_REQ = 1'b0; LS_WE = 1'b0;
    tick();
    tick();
    RSTN = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    RSTN = 1'b1; IF_REQ = 1'b1; LS_REQ = 1'b1; LS_WE = 1'b1;
    tick();
    tick();
    checks++;
    if (pulses !== 7'b0) begin
      errors++; $display("FAIL reset_pulses got=%b exp=%b", pulses, 7'b0);
    end
    checks++;
    if ({IF_RDATA, LS_RDATA} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata got=%h/%h exp=0", IF_RDATA, LS_RDATA);
    end
    checks++;
    if ({MEM_ADDR, MEM_WDATA, MEM_BE} !== '0) begin
      errors++; $display("FAIL reset_membus got=%h/%h/%h exp=0", MEM_ADDR, MEM_WDATA, MEM_BE);
    end
    do_reset();
  endtask

  task automatic test_single_load();
    logic [6:0] exp_p;
    do_reset();
    env_mem[32'h40 >> 2] = 32'hDEAD_BEEF;
    LS_REQ = 1'b1; LS_WE = 1'b0; LS_ADDR = 32'h40; LS_BE = 4'b0101; LS_WDATA = $urandom;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) LS_REQ = 1'b0;
      exp_p = {1'b0, 1'b0, c == 1, c == 4, c == 1, 1'b0, c >= 1 && c <= 4};
      checks++;
      if (pulses !== exp_p) begin
        errors++; $display("FAIL load_pulses cyc=%0d got=%b exp=%b", c, pulses, exp_p);
      end
      if (c == 1) begin
        checks++;
        if ({MEM_ADDR, MEM_BE} !== {32'h40, 4'hF}) begin
          errors++; $display("FAIL load_addr_be got=%h/%h exp=40/f", MEM_ADDR, MEM_BE);
        end
      end
      if (c == 4) begin
        checks++;
        if (LS_RDATA !== 32'hDEAD_BEEF) begin
          errors++; $display("FAIL load_rdata got=%h exp=deadbeef", LS_RDATA);
        end
      end
    end
  endtask

  // Runs straight after the load so LS_RDATA must go from DEADBEEF to 0.
  task automatic test_store();
    logic [6:0]  exp_p;
    logic [31:0] prev;
    prev = env_get(32'h80);
    LS_REQ = 1'b1; LS_WE = 1'b1; LS_ADDR = 32'h80; LS_WDATA = 32'h1234_5678; LS_BE = 4'b0011;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) LS_REQ = 1'b0;
      exp_p = {1'b0, 1'b0, c == 1, c == 4, c == 1, c == 1, c >= 1 && c <= 4};
      checks++;
      if (pulses !== exp_p) begin
        errors++; $display("FAIL store_pulses cyc=%0d got=%b exp=%b", c, pulses, exp_p);
      end
      if (c == 1) begin
        checks++;
        if ({MEM_ADDR, MEM_WDATA, MEM_BE} !== {32'h80, 32'h1234_5678, 4'b0011}) begin
          errors++; $display("FAIL store_bus got=%h/%h/%b exp=80/12345678/0011", MEM_ADDR, MEM_WDATA, MEM_BE);
        end
      end
      if (c == 4) begin
        checks++;
        if (LS_RDATA !== 32'h0) begin
          errors++; $display("FAIL store_rdata got=%h exp=0", LS_RDATA);
        end
      end
    end
    LS_WE = 1'b0;
    checks++;
    if (env_get(32'h80) !== {prev[31:16], 16'h5678}) begin
      errors++; $display("FAIL store_merge got=%h exp=%h", env_get(32'h80), {prev[31:16], 16'h5678});
    end
  endtask

  task automatic test_simultaneous();
    logic [6:0] exp_p;
    bit         if_first;
`ifdef IMEM_DMEM_ARB_RR_EN
    if_first = 1'b1;
`else
    if_first = 1'b0;
`endif
    do_reset();
    IF_REQ = 1'b1; IF_ADDR = 32'h200;
    LS_REQ = 1'b1; LS_WE = 1'b0; LS_ADDR = 32'h100;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (IF_GNT) IF_REQ = 1'b0;
      if (LS_GNT) LS_REQ = 1'b0;
      exp_p = {if_first ? c == 1 : c == 5, if_first ? c == 4 : c == 8,
               if_first ? c == 5 : c == 1, if_first ? c == 8 : c == 4,
               c == 1 || c == 5, 1'b0, c >= 1 && c <= 8};
      checks++;
      if (pulses !== exp_p) begin
        errors++; $display("FAIL simul_pulses cyc=%0d got=%b exp=%b", c, pulses, exp_p);
      end
      if (c == 8) begin
        checks++;
        if ({IF_RDATA, LS_RDATA} !== {init_word(32'h200), init_word(32'h100)}) begin
          errors++; $display("FAIL simul_rdata got=%h/%h exp=%h/%h", IF_RDATA, LS_RDATA,
                             init_word(32'h200), init_word(32'h100));
        end
      end
    end
  endtask

  task automatic test_starvation();
    int  n;
    bit  exp_if;
    do_reset();
    n = 0;
    IF_REQ = 1'b1; IF_ADDR = 32'h300;
    LS_REQ = 1'b1; LS_WE = 1'b0; LS_ADDR = 32'h400;
    for (int c = 1; c <= 200 && n < 10; c++) begin
      tick();
      if (IF_GNT || LS_GNT) begin
`ifdef IMEM_DMEM_ARB_RR_EN
        exp_if = (n % 2) == 0;
`else
        exp_if = (n % (STARVE_MAX + 1)) == STARVE_MAX;
`endif
        checks++;
        if ({IF_GNT, LS_GNT} !== {exp_if, !exp_if}) begin
          errors++; $display("FAIL starve_grant n=%0d got=%b exp=%b", n, {IF_GNT, LS_GNT}, {exp_if, !exp_if});
        end
        n++;
        IF_ADDR = IF_ADDR + 4;
        LS_ADDR = LS_ADDR + 4;
      end
    end
    checks++;
    if (n != 10) begin
      errors++; $display("FAIL starve_count got=%0d exp=10", n);
    end
    IF_REQ = 1'b0; LS_REQ = 1'b0;
    for (int c = 0; c < MEM_LAT + 4; c++) tick();
  endtask

  task automatic test_withdrawal();
    logic [6:0] exp_p;
    do_reset();
    LS_REQ = 1'b1; LS_WE = 1'b0; LS_ADDR = 32'h44; IF_ADDR = 32'h500;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) LS_REQ = 1'b0;
      IF_REQ = (c == 2);
      exp_p = {1'b0, 1'b0, c == 1, c == 4, c == 1, 1'b0, c >= 1 && c <= 4};
      checks++;
      if (pulses !== exp_p) begin
        errors++; $display("FAIL withdraw_pulses cyc=%0d got=%b exp=%b", c, pulses, exp_p);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [6:0] exp_p;
    do_reset();
    LS_REQ = 1'b1; LS_WE = 1'b0; LS_ADDR = 32'h48; IF_ADDR = 32'h20C;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) LS_REQ = 1'b0;
      RSTN   = (c == 2);
      IF_REQ = (c == 9);
      exp_p = {c == 10, c == 13, c == 1, 1'b0, c == 1 || c == 10, 1'b0,
               c == 1 || c == 2 || (c >= 10 && c <= 13)};
      checks++;
      if (pulses !== exp_p) begin
        errors++; $display("FAIL midrst_pulses cyc=%0d got=%b exp=%b", c, pulses, exp_p);
      end
      if (c == 3) begin
        checks++;
        if ({MEM_ADDR, MEM_WDATA, MEM_BE, IF_RDATA, LS_RDATA} !== '0) begin
          errors++; $display("FAIL midrst_zero got=%h/%h/%h exp=0", MEM_ADDR, MEM_BE, LS_RDATA);
        end
      end
      if (c == 13) begin
        checks++;
        if (IF_RDATA !== init_word(32'h20C)) begin
          errors++; $display("FAIL midrst_ifdata got=%h exp=%h", IF_RDATA, init_word(32'h20C));
        end
      end
    end
  endtask

  // ---------------- randomized run against a transaction model ----------------
  logic [31:0] model_mem [logic [31:0]];

  function automatic logic [31:0] model_get(input logic [31:0] a);
    if (model_mem.exists(a >> 2)) return model_mem[a >> 2];
    return init_word(a & 32'hFFFF_FFFC);
  endfunction

  task automatic test_random();
    int          next_arb, txn_arb, starve;
    bit          last_ls, t_if, t_we, win_if, if_was, ls_was;
    logic [31:0] t_addr, t_wdata, t_rdata, e_if_rd, e_ls_rd, w;
    logic [3:0]  t_be;
    logic [6:0]  exp_p;
    do_reset();
    next_arb = 0; txn_arb = -1; starve = 0; last_ls = 1'b1;
    e_if_rd = '0; e_ls_rd = '0;
    t_if = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0; t_rdata = '0; t_be = '0;
    for (int c = 0; c < NCYC; c++) begin
      // Expected outputs follow from the arbitration cycle of the current
      // transaction: grant one cycle later, response MEM_LAT+2 cycles later.
      exp_p = '0;
      if (txn_arb >= 0) begin
        if (c == txn_arb + 1) begin
          exp_p[6] = t_if; exp_p[4] = !t_if; exp_p[2] = 1'b1; exp_p[1] = t_we;
        end
        if (c == txn_arb + 2 + MEM_LAT) begin
          exp_p[5] = t_if; exp_p[3] = !t_if;
          if (t_if) e_if_rd = t_rdata; else e_ls_rd = t_rdata;
        end
        exp_p[0] = (c >= txn_arb + 1) && (c <= txn_arb + 2 + MEM_LAT);
      end
      checks++;
      if (pulses !== exp_p) begin
        errors++; $display("FAIL rnd_pulses cyc=%0d got=%b exp=%b", c, pulses, exp_p);
      end
      checks++;
      if ({IF_RDATA, LS_RDATA} !== {e_if_rd, e_ls_rd}) begin
        errors++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", c, IF_RDATA, LS_RDATA, e_if_rd, e_ls_rd);
      end
      if (txn_arb >= 0 && c == txn_arb + 1) begin
        checks++;
        if ({MEM_ADDR, MEM_BE} !== {t_addr, t_be} || (t_we && MEM_WDATA !== t_wdata)) begin
          errors++; $display("FAIL rnd_membus cyc=%0d got=%h/%h/%h exp=%h/%h/%h", c,
                             MEM_ADDR, MEM_BE, MEM_WDATA, t_addr, t_be, t_wdata);
        end
      end

      // Requesters: hold until granted, occasionally withdraw.
      if_was = IF_REQ;
      ls_was = LS_REQ;
      if (IF_GNT || (IF_REQ && $urandom_range(0, 31) == 0)) IF_REQ = 1'b0;
      if (LS_GNT || (LS_REQ && $urandom_range(0, 31) == 0)) LS_REQ = 1'b0;
      if ((!if_was || IF_GNT) && $urandom_range(0, 2) == 0) begin
        IF_REQ = 1'b1; IF_ADDR = 32'h1000 + 4 * $urandom_range(0, 15);
      end
      if ((!ls_was || LS_GNT) && $urandom_range(0, 2) == 0) begin
        LS_REQ = 1'b1; LS_WE = $urandom_range(0, 1);
        LS_ADDR = 32'h1000 + 4 * $urandom_range(0, 15);
        LS_WDATA = $urandom; LS_BE = 4'($urandom_range(1, 15));
      end

      // Arbitration with the requests visible at this cycle's edge.
      if (c == next_arb) begin
        if (IF_REQ && LS_REQ) begin
`ifdef IMEM_DMEM_ARB_RR_EN
          win_if = last_ls;
`else
          win_if = (starve == STARVE_MAX);
`endif
        end else begin
          win_if = IF_REQ;
        end
        starve = (!IF_REQ || win_if) ? 0 : ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX);
        if (IF_REQ || LS_REQ) begin
          last_ls = !win_if;
          txn_arb = c;
          t_if    = win_if;
          t_we    = !win_if && LS_WE;
          t_addr  = win_if ? IF_ADDR : LS_ADDR;
          t_be    = t_we ? LS_BE : 4'hF;
          t_wdata = LS_WDATA;
          if (t_we) begin
            w = model_get(t_addr);
            for (int b = 0; b < BE_W; b++) if (t_be[b]) w[8*b +: 8] = t_wdata[8*b +: 8];
            model_mem[t_addr >> 2] = w;
            t_rdata = '0;
          end else begin
            t_rdata = model_get(t_addr);
          end
          next_arb = c + 2 + MEM_LAT;
        end else begin
          next_arb = c + 1;
        end
      end
      tick();
    end
    IF_REQ = 1'b0; LS_REQ = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_load();
    test_store();
    test_simultaneous();
    test_starvation();
    test_withdrawal();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
